// File: rtl/fp32_sub_seq.sv
// fp32_sub_seq: multi-cycle IEEE-754 single-precision subtractor, res = a - b.
// Alignment and normalisation each move one bit per cycle. Rounding is by
// truncation, and denormals are flushed to zero.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands a/b valid
//   in_ready   operands accepted (high only in IDLE)
//   a, b       minuend, subtrahend
//   out_valid  res valid, held until out_ready
//   out_ready  consumer takes res
//   res        a - b, truncated
//   cycle_cnt  cycles from accept to out_valid for the last op (saturating)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for operands; in_ready high
// UNPACK | negate b, flush denormals, swap by magnitude, resolve specials
// ALIGN  | shift smaller mantissa right one bit per cycle until diff==0
// ADD    | add or subtract the aligned magnitudes
// NORM   | carry shift right, or shift left until the hidden bit is set
// PACK   | drop guard bits and assemble res
// DONE   | out_valid high; wait for out_ready
module fp32_sub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CYC_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [CYC_W-1:0]       cycle_cnt
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int WM = MAN_W + 4;

  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] EXP_TOP   = EXP_ONES - EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic [MAN_W-1:0] MAN_ZERO  = '0;
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_NUM, K_ZERO, K_INF
  } kind_t;

  state_t state, state_nxt;

  logic [W-1:0]     a_r, b_r;
  logic             sign_r;
  logic             eff_sub_r;
  logic [EXP_W-1:0] exp_r;
  logic [EXP_W-1:0] diff_r;
  logic [WM-1:0]    man_a, man_b;
  logic [WM:0]      sum_r;
  kind_t            kind_r;

  // operand decode, used in UNPACK
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
  logic [WM-1:0]    full_a, full_b;
  logic             sp_hit;
  logic [W-1:0]     sp_res;

  assign sa     = a_r[W-1];
  assign sb     = ~b_r[W-1];
  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign ma     = a_r[MAN_W-1:0];
  assign mb     = b_r[MAN_W-1:0];
  assign a_nan  = (ea == EXP_ONES) && (ma != MAN_ZERO);
  assign b_nan  = (eb == EXP_ONES) && (mb != MAN_ZERO);
  assign a_inf  = (ea == EXP_ONES) && (ma == MAN_ZERO);
  assign b_inf  = (eb == EXP_ONES) && (mb == MAN_ZERO);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign full_a = a_zero ? '0 : {1'b1, ma, 3'b000};
  assign full_b = b_zero ? '0 : {1'b1, mb, 3'b000};
  assign a_ge   = {ea, ma} >= {eb, mb};

  always_comb begin
    sp_hit = 1'b0;
    sp_res = '0;
    if (a_nan || b_nan) begin
      sp_hit = 1'b1;
      sp_res = QNAN;
    end else if (a_inf && b_inf) begin
      sp_hit = 1'b1;
      // inf - inf with equal signs has no defined value
      sp_res = (a_r[W-1] == b_r[W-1]) ? QNAN : {sa, EXP_ONES, MAN_ZERO};
    end else if (a_inf) begin
      sp_hit = 1'b1;
      sp_res = {sa, EXP_ONES, MAN_ZERO};
    end else if (b_inf) begin
      sp_hit = 1'b1;
      sp_res = {sb, EXP_ONES, MAN_ZERO};
    end else if (a_r == b_r) begin
      sp_hit = 1'b1;
      sp_res = '0;
    end else if (b_zero) begin
      sp_hit = 1'b1;
      sp_res = a_zero ? {sa, {(W-1){1'b0}}} : a_r;
    end else if (a_zero) begin
      sp_hit = 1'b1;
      sp_res = {sb, b_r[W-2:0]};
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = sp_hit ? S_DONE : S_ALIGN;
      S_ALIGN:  if (diff_r == '0) state_nxt = S_ADD;
      S_ADD:    state_nxt = S_NORM;
      S_NORM: begin
        if (sum_r[WM] || (sum_r == '0) || sum_r[WM-1] || (exp_r <= EXP_ONE))
          state_nxt = S_PACK;
      end
      S_PACK:   state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      exp_r     <= '0;
      diff_r    <= '0;
      man_a     <= '0;
      man_b     <= '0;
      sum_r     <= '0;
      kind_r    <= K_NUM;
      res       <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state == S_IDLE && in_valid)
        cycle_cnt <= '0;
      else if (state != S_IDLE && state != S_DONE && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        S_UNPACK: begin
          kind_r    <= K_NUM;
          eff_sub_r <= sa ^ sb;
          if (sp_hit) begin
            res <= sp_res;
          end else if (a_ge) begin
            sign_r <= sa;
            exp_r  <= ea;
            man_a  <= full_a;
            man_b  <= full_b;
            diff_r <= ea - eb;
          end else begin
            sign_r <= sb;
            exp_r  <= eb;
            man_a  <= full_b;
            man_b  <= full_a;
            diff_r <= eb - ea;
          end
        end
        S_ALIGN: begin
          if (diff_r != '0) begin
            // everything would be shifted out anyway: clear in one step
            if (diff_r > MAX_SHIFT) begin
              man_b  <= '0;
              diff_r <= '0;
            end else begin
              man_b  <= man_b >> 1;
              diff_r <= diff_r - EXP_ONE;
            end
          end
        end
        S_ADD: begin
          if (eff_sub_r) sum_r <= {1'b0, man_a} - {1'b0, man_b};
          else           sum_r <= {1'b0, man_a} + {1'b0, man_b};
        end
        S_NORM: begin
          if (sum_r[WM]) begin
            sum_r <= sum_r >> 1;
            if (exp_r == EXP_TOP) kind_r <= K_INF;
            else                  exp_r  <= exp_r + EXP_ONE;
          end else if (sum_r == '0) begin
            kind_r <= K_ZERO;
            sign_r <= 1'b0;
          end else if (!sum_r[WM-1]) begin
            // one more left shift would take the exponent to 0: flush
            if (exp_r <= EXP_ONE) begin
              kind_r <= K_ZERO;
            end else begin
              sum_r <= sum_r << 1;
              exp_r <= exp_r - EXP_ONE;
            end
          end
        end
        S_PACK: begin
          case (kind_r)
            K_INF:   res <= {sign_r, EXP_ONES, MAN_ZERO};
            K_ZERO:  res <= {sign_r, {(W-1){1'b0}}};
            default: res <= {sign_r, exp_r, sum_r[WM-2:3]};
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_sub_seq.sv
module tb_fp32_sub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [5:0]  cycle_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;

  fp32_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // issue one op and take its result; timeout is reported through check_val
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] r, output logic [5:0] c);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    r = res;
    c = cycle_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] r;
    logic [5:0]  c;

    vecs[0]  = '{32'h412C0000, 32'h40100000, 32'h41080000}; // 10.75 - 2.25
    vecs[1]  = '{32'h40100000, 32'h412C0000, 32'hC1080000}; // swap path
    vecs[2]  = '{32'hC348E000, 32'hC3C87000, 32'h43480000}; // -200.875 - -400.875
    vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h00000000}; // a == b
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000}; // inf - inf
    vecs[5]  = '{32'hFF800000, 32'hFF800000, 32'h7FC00000}; // -inf - -inf
    vecs[6]  = '{32'h7F800000, 32'hFF800000, 32'h7F800000}; // inf - -inf
    vecs[7]  = '{32'h3F800000, 32'h7F800000, 32'hFF800000}; // 1 - inf
    vecs[8]  = '{32'h3F800000, 32'h7F800001, 32'h7FC00000}; // NaN operand
    vecs[9]  = '{32'h40490FDB, 32'h00000000, 32'h40490FDB}; // b zero
    vecs[10] = '{32'h00000000, 32'h3F800000, 32'hBF800000}; // a zero
    vecs[11] = '{32'h3FC00000, 32'h3F800000, 32'h3F000000}; // 1.5 - 1.0, renormalise
    vecs[12] = '{32'h3FC00000, 32'hBF800000, 32'h40200000}; // 1.5 + 1.0, carry
    vecs[13] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000}; // overflow to inf
    vecs[14] = '{32'h80800001, 32'h80800000, 32'h80000000}; // underflow flush, sign kept
    vecs[15] = '{32'h4D800000, 32'h3F800000, 32'h4D800000}; // diff > 26, b cleared

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3;
    check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_res",       res,                32'd0);
    check_val("rst_cycle_cnt", {26'd0, cycle_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, r, c);
      check_val($sformatf("vec%0d_res", i), r, vecs[i].r);
      if (i == 0)  check_val("vec0_cycles",  {26'd0, c}, 32'd7);
      if (i == 12) check_val("vec12_cycles", {26'd0, c}, 32'd5);
    end

    // back-pressure: result and flags hold while out_ready is low
    @(negedge clk);
    a = 32'h412C0000;
    b = 32'h40100000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      check_val($sformatf("hold%0d_res", n), res, 32'h41080000);
      check_val($sformatf("hold%0d_valid", n), {31'd0, out_valid}, 32'd1);
      check_val($sformatf("hold%0d_in_ready", n), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("release_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("release_out_valid", {31'd0, out_valid}, 32'd0);

    // async reset in the middle of a long alignment
    @(negedge clk);
    a = 32'h4B000000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_val("mid_busy", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_res",       res,                32'd0);
    check_val("abort_cycle_cnt", {26'd0, cycle_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("long", 32'h4B000000, 32'h3F800000, r, c);
    check_val("long_res",    r,          32'h4AFFFFFE);
    check_val("long_cycles", {26'd0, c}, 32'd29);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
